// File: rtl/game_pkg.sv
// Shared types for the game-state block: control modes, winner encoding and FSM states.
package game_pkg;

    typedef enum logic [1:0] {
        CTRL_UP1   = 2'b00,
        CTRL_UPBIG = 2'b01,
        CTRL_DN1   = 2'b10,
        CTRL_DNBIG = 2'b11
    } ctrl_mode_t;

    localparam logic [1:0] WHO_NONE  = 2'b00;
    localparam logic [1:0] WHO_WIN   = 2'b10;
    localparam logic [1:0] WHO_LOSE  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } game_state_t;

endpackage

// File: rtl/game_state_param_score_counter.sv
// Saturating hit tally; flags the increment that will land exactly on the target.
module score_counter #(
    parameter int SCORE_SIZE = 4,
    parameter int TARGET     = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_clear,
    input  logic                  i_inc,
    output logic [SCORE_SIZE-1:0] o_score,
    output logic                  o_reachNext
);

    localparam logic [SCORE_SIZE-1:0] TGT    = SCORE_SIZE'(TARGET);
    localparam logic [SCORE_SIZE-1:0] TGT_M1 = SCORE_SIZE'(TARGET - 1);
    localparam logic [SCORE_SIZE-1:0] ONE    = SCORE_SIZE'(1);

    logic [SCORE_SIZE-1:0] r_score;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_score <= '0;
        end else if (i_clear) begin
            r_score <= '0;
        end else if (i_inc && (r_score != TGT)) begin
            r_score <= r_score + ONE;
        end
    end

    // Lets the parent end the game on the same edge the score lands on the target.
    assign o_reachNext = i_inc && (r_score == TGT_M1);
    assign o_score     = r_score;

endmodule

// File: rtl/game_state_param.sv
// Up/down play counter with win/loss hit detection, saturating tallies and an IDLE/PLAY/OVER FSM.
module game_state_param
    import game_pkg::*;
#(
    parameter int COUNTER_SIZE = 4,
    parameter int SCORE_SIZE   = 4,
    parameter int WIN_TARGET   = 15,
    parameter int STEP_BIG     = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              control,
    input  logic                    en,
    input  logic [COUNTER_SIZE-1:0] i_value,
    input  logic                    INIT,
    output logic [COUNTER_SIZE-1:0] count,
    output logic                    win,
    output logic                    los,
    output logic [SCORE_SIZE-1:0]   win_score,
    output logic [SCORE_SIZE-1:0]   los_score,
    output logic [1:0]              who,
    output logic                    gameover
);

    localparam logic [COUNTER_SIZE-1:0] STEP_ONE = COUNTER_SIZE'(1);
    localparam logic [COUNTER_SIZE-1:0] STEP_B   = COUNTER_SIZE'(STEP_BIG);

    game_state_t             r_state;
    logic [COUNTER_SIZE-1:0] r_count;
    logic                    r_win;
    logic                    r_los;
    logic [1:0]              r_who;
    logic                    r_gameover;

    logic [COUNTER_SIZE-1:0] w_step;
    logic [COUNTER_SIZE-1:0] w_nextCount;
    logic                    w_counting;
    logic                    w_winHit;
    logic                    w_losHit;
    logic                    w_winReach;
    logic                    w_losReach;

    always_comb begin
        w_step      = STEP_ONE;
        w_nextCount = r_count;
        case (ctrl_mode_t'(control))
            CTRL_UP1:   begin w_step = STEP_ONE; w_nextCount = r_count + STEP_ONE; end
            CTRL_UPBIG: begin w_step = STEP_B;   w_nextCount = r_count + STEP_B;   end
            CTRL_DN1:   begin w_step = STEP_ONE; w_nextCount = r_count - STEP_ONE; end
            CTRL_DNBIG: begin w_step = STEP_B;   w_nextCount = r_count - STEP_B;   end
            default:    begin w_step = STEP_ONE; w_nextCount = r_count;            end
        endcase
    end

    // INIT outranks counting, so a load of all-ones/all-zeros never scores.
    assign w_counting = (r_state == ST_PLAY) && en && !INIT;
    assign w_winHit   = w_counting && (w_nextCount == '1);
    assign w_losHit   = w_counting && (w_nextCount == '0);

    score_counter #(
        .SCORE_SIZE (SCORE_SIZE),
        .TARGET     (WIN_TARGET)
    ) u_winScore (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (INIT),
        .i_inc       (w_winHit),
        .o_score     (win_score),
        .o_reachNext (w_winReach)
    );

    score_counter #(
        .SCORE_SIZE (SCORE_SIZE),
        .TARGET     (WIN_TARGET)
    ) u_losScore (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (INIT),
        .i_inc       (w_losHit),
        .o_score     (los_score),
        .o_reachNext (w_losReach)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_win      <= 1'b0;
            r_los      <= 1'b0;
            r_who      <= WHO_NONE;
            r_gameover <= 1'b0;
        end else if (INIT) begin
            r_state    <= ST_PLAY;
            r_count    <= i_value;
            r_win      <= 1'b0;
            r_los      <= 1'b0;
            r_who      <= WHO_NONE;
            r_gameover <= 1'b0;
        end else begin
            r_win <= w_winHit;
            r_los <= w_losHit;
            case (r_state)
                ST_PLAY: begin
                    if (en) begin
                        r_count <= w_nextCount;
                        if (w_winReach) begin
                            r_state    <= ST_OVER;
                            r_who      <= WHO_WIN;
                            r_gameover <= 1'b1;
                        end else if (w_losReach) begin
                            r_state    <= ST_OVER;
                            r_who      <= WHO_LOSE;
                            r_gameover <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count    = r_count;
    assign win      = r_win;
    assign los      = r_los;
    assign who      = r_who;
    assign gameover = r_gameover;

endmodule

// File: tb/tb_game_state_param.sv
// Self-checking bench for game_state_param: directed game scenarios plus random play vs. an integer model.
module tb_game_state_param;

    localparam int CS  = 4;
    localparam int SS  = 4;
    localparam int WT  = 15;
    localparam int SB  = 2;
    localparam int MOD = 1 << CS;

    logic          clk;
    logic          reset;
    logic [1:0]    control;
    logic          en;
    logic [CS-1:0] i_value;
    logic          INIT;
    logic [CS-1:0] count;
    logic          win;
    logic          los;
    logic [SS-1:0] win_score;
    logic [SS-1:0] los_score;
    logic [1:0]    who;
    logic          gameover;

    int total;
    int bad;

    // Reference model: game phase 0=idle 1=playing 2=finished, values held as plain integers.
    int mPhase;
    int mCount;
    int mWin;
    int mLos;
    int mWs;
    int mLs;
    int mWho;
    int mGo;

    game_state_param #(
        .COUNTER_SIZE (CS),
        .SCORE_SIZE   (SS),
        .WIN_TARGET   (WT),
        .STEP_BIG     (SB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .control   (control),
        .en        (en),
        .i_value   (i_value),
        .INIT      (INIT),
        .count     (count),
        .win       (win),
        .los       (los),
        .win_score (win_score),
        .los_score (los_score),
        .who       (who),
        .gameover  (gameover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mPhase = 0; mCount = 0; mWin = 0; mLos = 0;
        mWs = 0; mLs = 0; mWho = 0; mGo = 0;
    endtask

    task automatic modelEdge(input int ctl, input int e, input int val, input int init);
        int delta;
        if (init != 0) begin
            mPhase = 1; mCount = val; mWin = 0; mLos = 0;
            mWs = 0; mLs = 0; mWho = 0; mGo = 0;
        end else if (mPhase == 1 && e != 0) begin
            delta  = (ctl % 2 == 1) ? SB : 1;
            mCount = (ctl >= 2) ? (mCount - delta + MOD) % MOD : (mCount + delta) % MOD;
            mWin   = (mCount == MOD - 1) ? 1 : 0;
            mLos   = (mCount == 0) ? 1 : 0;
            if (mWin == 1 && mWs < WT) mWs++;
            if (mLos == 1 && mLs < WT) mLs++;
            if (mWin == 1 && mWs == WT) begin
                mPhase = 2; mWho = 2; mGo = 1;
            end else if (mLos == 1 && mLs == WT) begin
                mPhase = 2; mWho = 1; mGo = 1;
            end
        end else begin
            mWin = 0; mLos = 0;
        end
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".count"},     int'(count),     mCount);
        checkOutput({tag, ".win"},       int'(win),       mWin);
        checkOutput({tag, ".los"},       int'(los),       mLos);
        checkOutput({tag, ".win_score"}, int'(win_score), mWs);
        checkOutput({tag, ".los_score"}, int'(los_score), mLs);
        checkOutput({tag, ".who"},       int'(who),       mWho);
        checkOutput({tag, ".gameover"},  int'(gameover),  mGo);
    endtask

    // Drive inputs just after an edge, clock once, then compare against the model 1 time unit later.
    task automatic applyStimulus(input string tag, input int ctl, input int e, input int val, input int init);
        control = 2'(ctl);
        en      = 1'(e);
        i_value = CS'(val);
        INIT    = 1'(init);
        @(posedge clk);
        modelEdge(ctl, e, val, init);
        #1;
        compareAll(tag);
    endtask

    task automatic runEdges(input string tag, input int ctl, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, ctl, 1, 0, 0);
    endtask

    task automatic pulseReset(input string tag);
        reset = 1'b1;
        #1;
        modelReset();
        compareAll(tag);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        control = 2'b00;
        en = 1'b0;
        i_value = '0;
        INIT = 1'b0;
        modelReset();
        #2;
        compareAll("por");
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Idle after reset: counting enabled but no INIT, count stays 0.
        for (int i = 0; i < 4; i++) applyStimulus("idle", 0, 1, 0, 0);
        checkOutput("idle_hold", int'(count), 0);

        // Count up from 0 until the win tally ends the game.
        applyStimulus("up_init", 0, 1, 0, 1);
        runEdges("up", 0, 239);
        checkOutput("up_over",  int'(gameover),  1);
        checkOutput("up_who",   int'(who),       2);
        checkOutput("up_ws",    int'(win_score), 15);
        checkOutput("up_ls",    int'(los_score), 14);
        runEdges("up_frozen", 0, 5);
        checkOutput("up_frozen_cnt", int'(count), 15);
        checkOutput("up_frozen_win", int'(win), 0);

        // Count down from 1 until the loss tally ends the game.
        applyStimulus("dn_init", 2, 1, 1, 1);
        runEdges("dn", 2, 225);
        checkOutput("dn_over", int'(gameover), 1);
        checkOutput("dn_who",  int'(who),      1);
        checkOutput("dn_cnt",  int'(count),    0);
        runEdges("dn_frozen", 2, 3);

        // Big up steps from 0: all-ones never reached, loss every 8 edges.
        applyStimulus("big_init", 1, 1, 0, 1);
        for (int i = 0; i < 7; i++) applyStimulus("big_seq", 1, 1, 0, 0);
        checkOutput("big_seq_cnt", int'(count), 14);
        runEdges("big", 1, 113);
        checkOutput("big_over", int'(gameover),  1);
        checkOutput("big_who",  int'(who),       1);
        checkOutput("big_ws",   int'(win_score), 0);

        // Restart while over.
        applyStimulus("reinit", 3, 0, 7, 1);
        checkOutput("reinit_cnt", int'(count),     7);
        checkOutput("reinit_ls",  int'(los_score), 0);
        checkOutput("reinit_go",  int'(gameover),  0);
        checkOutput("reinit_who", int'(who),       0);

        // Pause mid-play.
        runEdges("pre_pause", 0, 9);
        for (int i = 0; i < 5; i++) applyStimulus("pause", $urandom_range(0, 3), 0, 0, 0);
        checkOutput("pause_cnt", int'(count), 0);
        checkOutput("pause_ls",  int'(los_score), 1);
        runEdges("post_pause", 3, 3);

        // Async reset between edges, then count must hold at 0 until INIT.
        #2;
        pulseReset("midrst");
        for (int i = 0; i < 4; i++) applyStimulus("rst_idle", 0, 1, 0, 0);
        checkOutput("rst_idle_cnt", int'(count), 0);

        // Load all-ones: no win on load, first step wraps to zero.
        applyStimulus("ld15", 0, 1, 15, 1);
        checkOutput("ld15_win", int'(win), 0);
        applyStimulus("ld15_step", 0, 1, 0, 0);
        checkOutput("ld15_cnt", int'(count),     0);
        checkOutput("ld15_los", int'(los),       1);
        checkOutput("ld15_ls",  int'(los_score), 1);

        // Random play, with occasional INIT and mid-cycle resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                #2;
                pulseReset("rnd_rst");
            end
            applyStimulus("rnd", $urandom_range(0, 3), ($urandom_range(0, 3) != 0) ? 1 : 0,
                          $urandom_range(0, MOD - 1), ($urandom_range(0, 39) == 0) ? 1 : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
